// File: rtl/eer_pkg.sv
// Shared types and constants for the rewardv2 TX path: word sizes, packet-type
// encoding, packet lengths and the serializer state encoding.
package eer_pkg;

    localparam int WORD_WIDTH = 16;
    localparam int CNT_WIDTH  = 5;
    localparam int IDX_WIDTH  = 4;
    localparam int MAX_WORDS  = 8;

    localparam logic [IDX_WIDTH-1:0] HB_WORDS   = 4'd5;
    localparam logic [IDX_WIDTH-1:0] FULL_WORDS = 4'd8;

    typedef enum logic [2:0] {
        PKT_HB = 3'b000,
        PKT_T1 = 3'b001,
        PKT_T2 = 3'b010,
        PKT_T3 = 3'b011,
        PKT_T4 = 3'b100,
        PKT_T5 = 3'b101,
        PKT_T6 = 3'b110,
        PKT_T7 = 3'b111
    } pkt_type_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_BACKOFF = 3'd1,
        ST_SEND    = 3'd2,
        ST_CKSUM   = 3'd3,
        ST_DONE    = 3'd4
    } ser_state_t;

    // Heartbeats carry only header + four payload words; every other type carries all seven.
    function automatic logic [IDX_WIDTH-1:0] pkt_len(input logic [2:0] ptype);
        if (ptype == PKT_HB) begin
            return HB_WORDS;
        end else begin
            return FULL_WORDS;
        end
    endfunction

endpackage

// File: rtl/backoff_counter.sv
// Carrier-sense backoff counter: load (or reload on a busy medium), count down
// to zero while the medium is idle, and flag zero.
module backoff_counter
    import eer_pkg::*;
(
    input  logic                 clk,
    input  logic                 nrst,
    input  logic                 load_en,
    input  logic [CNT_WIDTH-1:0] load_val,
    input  logic                 dec_en,
    output logic                 zero
);

    logic [CNT_WIDTH-1:0] cnt_r;

    // Counter register: load has priority, decrement saturates at zero
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt_r <= 5'd0;
        end else if (load_en) begin
            cnt_r <= load_val;
        end else if (dec_en && (cnt_r != 5'd0)) begin
            cnt_r <= cnt_r - 5'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign zero = (cnt_r == 5'd0);

endmodule

// File: rtl/tx_packet_serializer.sv
// Captures a rewardv2 packet on reward_done, waits a node-seeded carrier-sense
// backoff, streams the packet words plus an XOR checksum on a valid/ready port,
// then pulses ok_to_send back to rewardv2.
module tx_packet_serializer
    import eer_pkg::*;
#(
    parameter int WORD_WIDTH  = 16,
    parameter int BACKOFF_MIN = 2
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  reward_done,
    input  logic [15:0]           myNodeID,
    input  logic [2:0]            rPacketType,
    input  logic                  tx_setting,
    input  logic [5:0]            rTimeslot,
    input  logic [WORD_WIDTH-1:0] rSourceID,
    input  logic [WORD_WIDTH-1:0] rDestinationID,
    input  logic [WORD_WIDTH-1:0] rSourceHops,
    input  logic [WORD_WIDTH-1:0] rQValue,
    input  logic [WORD_WIDTH-1:0] rEnergyLeft,
    input  logic [WORD_WIDTH-1:0] rChosenCH,
    input  logic [WORD_WIDTH-1:0] rHopsFromCH,
    input  logic                  channel_clear,
    input  logic                  tx_ready,
    output logic [WORD_WIDTH-1:0] tx_data,
    output logic                  tx_valid,
    output logic                  tx_last,
    output logic                  ok_to_send,
    output logic                  busy,
    output logic                  drop_pulse
);

    ser_state_t             state_r;
    logic [WORD_WIDTH-1:0]  words_r [0:MAX_WORDS-1];
    logic [IDX_WIDTH-1:0]   len_r;
    logic [IDX_WIDTH-1:0]   idx_r;
    logic [WORD_WIDTH-1:0]  csum_r;
    logic [CNT_WIDTH-1:0]   seed_r;

    logic [WORD_WIDTH-1:0]  header_s;
    logic [CNT_WIDTH-1:0]   live_seed_s;
    logic [WORD_WIDTH-1:0]  cur_word_s;
    logic [WORD_WIDTH-1:0]  next_word_s;
    logic [IDX_WIDTH-1:0]   idx_next_s;
    logic [WORD_WIDTH-1:0]  csum_next_s;
    logic                   last_word_s;
    logic                   load_en_s;
    logic [CNT_WIDTH-1:0]   load_val_s;
    logic                   dec_en_s;
    logic                   cnt_zero_s;
    logic [11:0]            unused_node_bits_s;

    // Only the low nibble of the node ID seeds the backoff
    assign unused_node_bits_s = myNodeID[15:4];

    // Header assembly, word selection, checksum step and backoff-counter control
    always_comb begin
        header_s    = {rPacketType, tx_setting, {(WORD_WIDTH-10){1'b0}}, rTimeslot};
        live_seed_s = CNT_WIDTH'(BACKOFF_MIN) + {1'b0, myNodeID[3:0]};
        cur_word_s  = words_r[idx_r[2:0]];
        idx_next_s  = idx_r + 4'd1;
        next_word_s = words_r[idx_next_s[2:0]];
        csum_next_s = csum_r ^ tx_data;
        last_word_s = (idx_next_s == len_r);
        load_en_s   = 1'b0;
        load_val_s  = seed_r;
        dec_en_s    = 1'b0;
        if (state_r == ST_IDLE) begin
            if (reward_done) begin
                load_en_s  = 1'b1;
                load_val_s = live_seed_s;
            end else begin
                load_en_s  = 1'b0;
            end
        end else if (state_r == ST_BACKOFF) begin
            if (!channel_clear) begin
                load_en_s = 1'b1;
            end else if (!cnt_zero_s) begin
                dec_en_s  = 1'b1;
            end else begin
                dec_en_s  = 1'b0;
            end
        end else begin
            load_en_s = 1'b0;
        end
    end

    backoff_counter u_backoff (
        .clk      (clk),
        .nrst     (nrst),
        .load_en  (load_en_s),
        .load_val (load_val_s),
        .dec_en   (dec_en_s),
        .zero     (cnt_zero_s)
    );

    // Packet FSM: capture, backoff wait, word streaming, checksum, handshake back to rewardv2
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_r    <= ST_IDLE;
            len_r      <= 4'd0;
            idx_r      <= 4'd0;
            csum_r     <= '0;
            seed_r     <= 5'd0;
            tx_data    <= '0;
            tx_valid   <= 1'b0;
            tx_last    <= 1'b0;
            ok_to_send <= 1'b0;
            busy       <= 1'b0;
            drop_pulse <= 1'b0;
            for (int i = 0; i < MAX_WORDS; i++) begin
                words_r[i] <= '0;
            end
        end else begin
            drop_pulse <= reward_done && (state_r != ST_IDLE);
            ok_to_send <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (reward_done) begin
                        words_r[0] <= header_s;
                        words_r[1] <= rSourceID;
                        words_r[2] <= rDestinationID;
                        words_r[3] <= rSourceHops;
                        words_r[4] <= rQValue;
                        words_r[5] <= rEnergyLeft;
                        words_r[6] <= rChosenCH;
                        words_r[7] <= rHopsFromCH;
                        len_r      <= pkt_len(rPacketType);
                        seed_r     <= live_seed_s;
                        idx_r      <= 4'd0;
                        csum_r     <= '0;
                        busy       <= 1'b1;
                        state_r    <= ST_BACKOFF;
                    end else begin
                        busy       <= 1'b0;
                        state_r    <= ST_IDLE;
                    end
                end
                ST_BACKOFF: begin
                    if (channel_clear && cnt_zero_s) begin
                        state_r <= ST_SEND;
                    end else begin
                        state_r <= ST_BACKOFF;
                    end
                end
                ST_SEND: begin
                    // First SEND cycle only presents word 0; afterwards each accept advances
                    if (!tx_valid) begin
                        tx_valid <= 1'b1;
                        tx_data  <= cur_word_s;
                    end else if (tx_ready) begin
                        csum_r <= csum_next_s;
                        if (last_word_s) begin
                            tx_data <= csum_next_s;
                            tx_last <= 1'b1;
                            state_r <= ST_CKSUM;
                        end else begin
                            idx_r   <= idx_next_s;
                            tx_data <= next_word_s;
                        end
                    end else begin
                        tx_data <= tx_data;
                    end
                end
                ST_CKSUM: begin
                    if (tx_ready) begin
                        tx_valid   <= 1'b0;
                        tx_last    <= 1'b0;
                        tx_data    <= '0;
                        ok_to_send <= 1'b1;
                        state_r    <= ST_DONE;
                    end else begin
                        state_r    <= ST_CKSUM;
                    end
                end
                ST_DONE: begin
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    tx_valid <= 1'b0;
                    tx_last  <= 1'b0;
                    tx_data  <= '0;
                    busy     <= 1'b0;
                    state_r  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tx_packet_serializer.sv
// Self-checking bench for tx_packet_serializer. A packet-level model builds the
// expected word list, checksum and valid latency from the field values; a
// monitor collects accepted words from the TX port for comparison.
module tb_tx_packet_serializer;

    logic        clk;
    logic        nrst;
    logic        reward_done;
    logic [15:0] myNodeID;
    logic [2:0]  rPacketType;
    logic        tx_setting;
    logic [5:0]  rTimeslot;
    logic [15:0] rSourceID, rDestinationID, rSourceHops, rQValue;
    logic [15:0] rEnergyLeft, rChosenCH, rHopsFromCH;
    logic        channel_clear;
    logic        tx_ready;
    logic [15:0] tx_data;
    logic        tx_valid, tx_last, ok_to_send, busy, drop_pulse;

    tx_packet_serializer #(.WORD_WIDTH(16), .BACKOFF_MIN(2)) dut (
        .clk(clk), .nrst(nrst), .reward_done(reward_done), .myNodeID(myNodeID),
        .rPacketType(rPacketType), .tx_setting(tx_setting), .rTimeslot(rTimeslot),
        .rSourceID(rSourceID), .rDestinationID(rDestinationID), .rSourceHops(rSourceHops),
        .rQValue(rQValue), .rEnergyLeft(rEnergyLeft), .rChosenCH(rChosenCH),
        .rHopsFromCH(rHopsFromCH), .channel_clear(channel_clear), .tx_ready(tx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last),
        .ok_to_send(ok_to_send), .busy(busy), .drop_pulse(drop_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    // packet model
    logic [2:0]  m_type;
    logic        m_set;
    logic [5:0]  m_ts;
    logic [15:0] m_node;
    logic [15:0] m_fld [0:6];
    logic [15:0] exp_q [$];
    int          exp_lat;

    // monitor results
    logic [15:0] got_q [$];
    logic        last_q [$];
    int          rise_d, ok_cnt, drop_cnt, stable_bad, cap_cyc;
    logic        post_ok1, post_busy2;
    bit          timed_out;
    int          inj_word = -1;
    bit          inj_in_done = 0;

    // Expected stream straight from the packet rules: header, payload by type, XOR checksum
    task automatic build_expected();
        logic [15:0] cs;
        int n;
        exp_q.delete();
        exp_q.push_back({m_type, m_set, 6'b000000, m_ts});
        n = (m_type == 3'b000) ? 4 : 7;
        for (int i = 0; i < n; i++) exp_q.push_back(m_fld[i]);
        cs = 16'h0000;
        foreach (exp_q[i]) cs = cs ^ exp_q[i];
        exp_q.push_back(cs);
        exp_lat = 2 + int'(m_node[3:0]) + 2;
    endtask

    task automatic random_model(input bit hb);
        m_type = hb ? 3'b000 : 3'($urandom_range(1, 7));
        m_set  = 1'($urandom_range(0, 1));
        m_ts   = 6'($urandom_range(0, 63));
        m_node = 16'($urandom);
        for (int i = 0; i < 7; i++) m_fld[i] = 16'($urandom);
        build_expected();
    endtask

    task automatic scramble_inputs();
        myNodeID = 16'($urandom); rPacketType = 3'($urandom); tx_setting = 1'($urandom);
        rTimeslot = 6'($urandom); rSourceID = 16'($urandom); rDestinationID = 16'($urandom);
        rSourceHops = 16'($urandom); rQValue = 16'($urandom); rEnergyLeft = 16'($urandom);
        rChosenCH = 16'($urandom); rHopsFromCH = 16'($urandom);
    endtask

    // Called at a falling edge: present fields with a one-cycle reward_done
    task automatic start_packet();
        myNodeID = m_node; rPacketType = m_type; tx_setting = m_set; rTimeslot = m_ts;
        rSourceID = m_fld[0]; rDestinationID = m_fld[1]; rSourceHops = m_fld[2];
        rQValue = m_fld[3]; rEnergyLeft = m_fld[4]; rChosenCH = m_fld[5]; rHopsFromCH = m_fld[6];
        reward_done = 1'b1;
        @(negedge clk);
        reward_done = 1'b0;
        cap_cyc = cyc;
        scramble_inputs();
    endtask

    // Monitor: drive tx_ready, record accepted words, then observe the DONE/IDLE cycles
    task automatic collect(input int ready_mode, input int stop_after);
        bit fin, prev_stall, injected;
        logic [15:0] prev_data;
        int post;
        got_q.delete(); last_q.delete();
        rise_d = -1; ok_cnt = 0; drop_cnt = 0; stable_bad = 0; timed_out = 0;
        fin = 0; prev_stall = 0; prev_data = 16'h0000; injected = 0; post = -1;
        post_ok1 = 1'b0; post_busy2 = 1'b1;
        for (int c = 0; c < 600 && !fin; c++) begin
            @(negedge clk);
            reward_done = 1'b0;
            if (ok_to_send) ok_cnt++;
            if (drop_pulse) drop_cnt++;
            if (prev_stall && (tx_valid !== 1'b1 || tx_data !== prev_data)) stable_bad++;
            if (tx_valid && rise_d < 0) rise_d = cyc - cap_cyc;
            if (post >= 0) begin
                post++;
                if (post == 1) begin
                    post_ok1 = ok_to_send;
                    if (inj_in_done) begin reward_done = 1'b1; scramble_inputs(); end
                end else begin
                    post_busy2 = busy;
                    fin = 1;
                end
            end else begin
                case (ready_mode)
                    0:       tx_ready = 1'b1;
                    1:       tx_ready = ~tx_ready;
                    default: tx_ready = 1'($urandom_range(0, 1));
                endcase
                if (!injected && inj_word >= 0 && tx_valid && got_q.size() == inj_word) begin
                    reward_done = 1'b1;
                    scramble_inputs();
                    injected = 1;
                end
                if (tx_valid && tx_ready) begin
                    got_q.push_back(tx_data);
                    last_q.push_back(tx_last);
                    if (tx_last) post = 0;
                    if (stop_after > 0 && got_q.size() == stop_after) fin = 1;
                end
                prev_stall = tx_valid && !tx_ready;
                prev_data  = tx_data;
            end
        end
        if (!fin) timed_out = 1;
    endtask

    task automatic test_reset();
        nrst = 1'b0; reward_done = 1'b0; channel_clear = 1'b1; tx_ready = 1'b1;
        scramble_inputs();
        repeat (3) @(negedge clk);
        n_tests++;
        if ({tx_valid, tx_last, ok_to_send, busy, drop_pulse} !== 5'b00000) begin
            n_fail++; $display("FAIL reset_flags: got %b expected 00000", {tx_valid, tx_last, ok_to_send, busy, drop_pulse});
        end
        n_tests++;
        if (tx_data !== 16'h0000) begin n_fail++; $display("FAIL reset_data: got %h expected 0000", tx_data); end
        nrst = 1'b1;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({tx_valid, busy, ok_to_send} !== 3'b000) begin
            n_fail++; $display("FAIL idle_after_reset: got %b expected 000", {tx_valid, busy, ok_to_send});
        end
    endtask

    task automatic test_heartbeat();
        for (int p = 0; p < 3; p++) begin
            random_model(1'b1);
            if (p == 0) begin
                m_set = 1'b0; m_ts = 6'd1; m_node = 16'h000c;
                m_fld[0] = 16'h000c; m_fld[1] = 16'hffff; m_fld[2] = 16'h0003; m_fld[3] = 16'h3555;
                build_expected();
            end
            start_packet();
            collect((p == 0) ? 0 : 2, 0);
            n_tests++;
            if (timed_out || got_q.size() != exp_q.size()) begin
                n_fail++; $display("FAIL hb_len[%0d]: got %0d words (timeout=%0d) expected %0d", p, got_q.size(), timed_out, exp_q.size());
            end
            for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
                n_tests++;
                if (got_q[i] !== exp_q[i] || last_q[i] !== (i == exp_q.size() - 1)) begin
                    n_fail++; $display("FAIL hb_word[%0d][%0d]: got %h last=%b expected %h", p, i, got_q[i], last_q[i], exp_q[i]);
                end
            end
            if (p == 0) begin
                n_tests++;
                if (got_q.size() == 6 && got_q[5] !== 16'hcaa4) begin
                    n_fail++; $display("FAIL hb_cksum: got %h expected caa4", got_q[5]);
                end
                n_tests++;
                if (rise_d != 16) begin n_fail++; $display("FAIL hb_latency: got %0d expected 16", rise_d); end
            end
            n_tests++;
            if (ok_cnt != 1 || post_ok1 !== 1'b1 || post_busy2 !== 1'b0) begin
                n_fail++; $display("FAIL hb_ok[%0d]: got ok_cnt=%0d ok1=%b busy2=%b expected 1 1 0", p, ok_cnt, post_ok1, post_busy2);
            end
        end
    endtask

    task automatic test_full_packet();
        for (int p = 0; p < 3; p++) begin
            random_model(1'b0);
            if (p == 0) m_type = 3'b101;
            build_expected();
            start_packet();
            collect((p == 0) ? 1 : 2, 0);
            n_tests++;
            if (timed_out || got_q.size() != 9) begin
                n_fail++; $display("FAIL full_len[%0d]: got %0d words (timeout=%0d) expected 9", p, got_q.size(), timed_out);
            end
            for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
                n_tests++;
                if (got_q[i] !== exp_q[i] || last_q[i] !== (i == exp_q.size() - 1)) begin
                    n_fail++; $display("FAIL full_word[%0d][%0d]: got %h last=%b expected %h", p, i, got_q[i], last_q[i], exp_q[i]);
                end
            end
            n_tests++;
            if (stable_bad != 0) begin n_fail++; $display("FAIL full_hold[%0d]: got %0d changes under stall expected 0", p, stable_bad); end
            n_tests++;
            if (rise_d != exp_lat || ok_cnt != 1) begin
                n_fail++; $display("FAIL full_timing[%0d]: got rise=%0d ok=%0d expected %0d 1", p, rise_d, ok_cnt, exp_lat);
            end
        end
    endtask

    task automatic test_carrier_sense();
        int k;
        random_model(1'b0);
        m_node = 16'h000c;
        build_expected();
        start_packet();
        k = $urandom_range(1, 10);
        repeat (k) @(negedge clk);
        channel_clear = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_tests++;
            if (tx_valid !== 1'b0 || busy !== 1'b1) begin
                n_fail++; $display("FAIL cs_hold[%0d]: got valid=%b busy=%b expected 0 1", i, tx_valid, busy);
            end
        end
        channel_clear = 1'b1;
        cap_cyc = cyc;
        collect(0, 0);
        n_tests++;
        if (rise_d != 16) begin n_fail++; $display("FAIL cs_latency: got %0d expected 16", rise_d); end
        n_tests++;
        if (timed_out || got_q.size() != exp_q.size() || got_q[got_q.size()-1] !== exp_q[exp_q.size()-1]) begin
            n_fail++; $display("FAIL cs_packet: got %0d words expected %0d", got_q.size(), exp_q.size());
        end
    endtask

    task automatic test_collision();
        random_model(1'b0);
        start_packet();
        inj_word = $urandom_range(1, 7);
        collect(2, 0);
        inj_word = -1;
        n_tests++;
        if (drop_cnt != 1) begin n_fail++; $display("FAIL col_drop: got %0d pulses expected 1", drop_cnt); end
        n_tests++;
        if (timed_out || got_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL col_len: got %0d expected %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_tests++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL col_word[%0d]: got %h expected %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid_send();
        random_model(1'b0);
        start_packet();
        collect(0, 3);
        @(posedge clk);
        #2 nrst = 1'b0;
        #1;
        n_tests++;
        if ({tx_valid, busy, ok_to_send, tx_last} !== 4'b0000) begin
            n_fail++; $display("FAIL rst_abort: got %b expected 0000", {tx_valid, busy, ok_to_send, tx_last});
        end
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        random_model($urandom_range(0, 1) == 1);
        start_packet();
        collect(2, 0);
        n_tests++;
        if (timed_out || got_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL rst_len: got %0d expected %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_tests++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL rst_word[%0d]: got %h expected %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        random_model(1'b0);
        start_packet();
        inj_in_done = 1;
        collect(0, 0);
        inj_in_done = 0;
        n_tests++;
        if (drop_cnt != 1 || post_busy2 !== 1'b0 || ok_cnt != 1) begin
            n_fail++; $display("FAIL b2b_done_drop: got drop=%0d busy=%b ok=%0d expected 1 0 1", drop_cnt, post_busy2, ok_cnt);
        end
        n_tests++;
        if (timed_out || got_q.size() != exp_q.size() || got_q[got_q.size()-1] !== exp_q[exp_q.size()-1]) begin
            n_fail++; $display("FAIL b2b_first: got %0d words expected %0d", got_q.size(), exp_q.size());
        end
        random_model(1'b0);
        start_packet();
        n_tests++;
        if (busy !== 1'b1 || drop_pulse !== 1'b0) begin
            n_fail++; $display("FAIL b2b_accept: got busy=%b drop=%b expected 1 0", busy, drop_pulse);
        end
        collect(1, 0);
        n_tests++;
        if (rise_d != exp_lat || drop_cnt != 0) begin
            n_fail++; $display("FAIL b2b_backoff: got rise=%0d drop=%0d expected %0d 0", rise_d, drop_cnt, exp_lat);
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_tests++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL b2b_word[%0d]: got %h expected %h", i, got_q[i], exp_q[i]);
            end
        end
        n_tests++;
        if (timed_out || got_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL b2b_len: got %0d expected %0d", got_q.size(), exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_heartbeat();
        test_full_packet();
        test_carrier_sense();
        test_collision();
        test_reset_mid_send();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
